// File: rtl/clm_round_ctrl.sv
// clm_round_ctrl: stage/round sequencer for the CLM masked-AES datapath (control only).
// Define CLM_WATCHDOG_EN to add a per-wait-state watchdog with the wd_err output.
module clm_round_ctrl #(
    parameter int unsigned ROUNDS = 10
`ifdef CLM_WATCHDOG_EN
    ,
    parameter int unsigned WD_LIMIT = 255
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drdy_i,
    input  logic       params_done,
    input  logic       sbox_drdy,
    input  logic       ke_drdy,
    output logic [3:0] stage,
    output logic [3:0] round,
    output logic       load_data,
    output logic       sbox_start,
    output logic       ke_start,
    output logic       ke_first_round,
    output logic       busy,
    output logic       drdy_o
`ifdef CLM_WATCHDOG_EN
    ,
    output logic       wd_err
`endif
);

    localparam int unsigned ROUND_BITS = 4;
    localparam logic [ROUND_BITS-1:0] LAST_ROUND = ROUND_BITS'(ROUNDS);

    typedef enum logic [3:0] {
        IDLE               = 4'd0,
        CALC_PARAMS        = 4'd1,
        PREP_DATA          = 4'd2,
        ADD_ROUND_KEY      = 4'd3,
        SUB_BYTES          = 4'd4,
        SHIFT_ROWS         = 4'd5,
        MIX_COLS           = 4'd6,
        KEY_EXPAND_WAIT    = 4'd7,
        ADD_ROUND_KEY_LAST = 4'd8,
        MOD_P              = 4'd9,
        PREP_OUTPUT        = 4'd10
    } stages_t;

    stages_t               state;
    stages_t               state_base;
    stages_t               state_next;
    logic [ROUND_BITS-1:0] round_q;
    logic [ROUND_BITS-1:0] round_base;
    logic [ROUND_BITS-1:0] round_next;
    logic                  ke_pending;
    logic                  ke_done_q;
    logic                  ke_go;
    logic                  kew_exit;
    logic                  abort;

    assign stage = state;
    assign round = round_q;

    always_comb begin
        state_base = state;
        round_base = round_q;
        ke_go      = 1'b0;
        kew_exit   = 1'b0;
        unique case (state)
            IDLE:        if (drdy_i) state_base = CALC_PARAMS;
            CALC_PARAMS: if (params_done) state_base = PREP_DATA;
            PREP_DATA: begin
                round_base = '0;
                state_base = ADD_ROUND_KEY;
            end
            ADD_ROUND_KEY: begin
                ke_go = (round_q < LAST_ROUND);
                if (round_q < LAST_ROUND) round_base = round_q + 1'b1;
                state_base = SUB_BYTES;
            end
            // sbox_start is high only in the entry cycle, so it masks a stale sbox_drdy there
            SUB_BYTES:   if (sbox_drdy && !sbox_start) state_base = SHIFT_ROWS;
            SHIFT_ROWS:  state_base = (round_q < LAST_ROUND) ? MIX_COLS : KEY_EXPAND_WAIT;
            MIX_COLS:    state_base = KEY_EXPAND_WAIT;
            KEY_EXPAND_WAIT: begin
                if (ke_done_q || ke_drdy) begin
                    kew_exit   = 1'b1;
                    state_base = (round_q < LAST_ROUND) ? ADD_ROUND_KEY : ADD_ROUND_KEY_LAST;
                end
            end
            ADD_ROUND_KEY_LAST: state_base = MOD_P;
            MOD_P:              state_base = PREP_OUTPUT;
            PREP_OUTPUT:        state_base = IDLE;
            default:            state_base = IDLE;
        endcase
    end

`ifdef CLM_WATCHDOG_EN
    logic [7:0] wd_cnt;
    logic       wd_wait;

    assign wd_wait = (state == CALC_PARAMS) || (state == SUB_BYTES) || (state == KEY_EXPAND_WAIT);
    assign abort   = wd_wait && (state_base == state) && (wd_cnt == 8'(WD_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            wd_err <= abort;
            if (state_next != state) wd_cnt <= '0;
            else if (wd_wait)        wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    assign state_next = abort ? IDLE : state_base;
    assign round_next = abort ? '0 : round_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            round_q        <= '0;
            ke_pending     <= 1'b0;
            ke_done_q      <= 1'b0;
            load_data      <= 1'b0;
            sbox_start     <= 1'b0;
            ke_start       <= 1'b0;
            ke_first_round <= 1'b0;
            busy           <= 1'b0;
            drdy_o         <= 1'b0;
        end else begin
            state          <= state_next;
            round_q        <= round_next;
            load_data      <= (state_next == PREP_DATA);
            sbox_start     <= (state_next == SUB_BYTES) && (state != SUB_BYTES);
            ke_start       <= (state_next == ADD_ROUND_KEY) && (round_next < LAST_ROUND);
            ke_first_round <= (state_next == ADD_ROUND_KEY) && (round_next == '0);
            busy           <= (state_next != IDLE);
            drdy_o         <= (state_next == PREP_OUTPUT);
            if (abort) begin
                ke_pending <= 1'b0;
                ke_done_q  <= 1'b0;
            end else begin
                // a new ke_start wins over a coincident ke_drdy; exit clearing wins over latching
                if (ke_go)        ke_pending <= 1'b1;
                else if (ke_drdy) ke_pending <= 1'b0;
                if (kew_exit)                             ke_done_q <= 1'b0;
                else if (!ke_go && ke_drdy && ke_pending) ke_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clm_round_ctrl.sv
// Directed, table-driven bench for clm_round_ctrl with handshake responders and hand-written corner sequences.
module tb_clm_round_ctrl;

    localparam int S_IDLE = 0, S_CALC = 1, S_PREP = 2, S_ARK = 3, S_SB = 4, S_SR = 5;
    localparam int S_MC = 6, S_KEW = 7, S_ARKL = 8, S_MODP = 9, S_OUT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drdy_i = 1'b0;
    logic       params_done = 1'b0;
    logic       sbox_drdy = 1'b0;
    logic       ke_drdy = 1'b0;
    logic [3:0] stage;
    logic [3:0] round;
    logic       load_data, sbox_start, ke_start, ke_first_round, busy, drdy_o;
`ifdef CLM_WATCHDOG_EN
    logic       wd_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    clm_round_ctrl #(.ROUNDS(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .drdy_i         (drdy_i),
        .params_done    (params_done),
        .sbox_drdy      (sbox_drdy),
        .ke_drdy        (ke_drdy),
        .stage          (stage),
        .round          (round),
        .load_data      (load_data),
        .sbox_start     (sbox_start),
        .ke_start       (ke_start),
        .ke_first_round (ke_first_round),
        .busy           (busy),
        .drdy_o         (drdy_o)
`ifdef CLM_WATCHDOG_EN
        ,
        .wd_err         (wd_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int params_wait;
        int sbox_delay;
        int sbox_always;
        int ke_delay;
        int slow_round;
        int slow_delay;
        int spur_stage;
        int spur_round;
        int extra_round;
        int exp_lat;
        int exp_kew;
        int exp_long_round;
    } vec_t;

    vec_t vecs[10];

    int lat, n_drdy, n_kes, n_sbs, n_kfr, n_mc, n_load, n_kew, max_round, long_round, inv_err, round_err, fin_ok;
    int ke_due[$];
    int sb_due[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One encryption; responders answer ke_start/sbox_start after the vector's delays.
    task automatic run_op(input vec_t v);
        int cyc, tail, st, rd, prev_st, prev_rd;
        bit spur_done, extra_done, fin;
        lat = 0; n_drdy = 0; n_kes = 0; n_sbs = 0; n_kfr = 0; n_mc = 0; n_load = 0;
        n_kew = 0; max_round = 0; long_round = -1; inv_err = 0; round_err = 0;
        ke_due.delete();
        sb_due.delete();
        spur_done = 0; extra_done = 0; fin = 0; tail = 0;
        prev_st = int'(stage);
        prev_rd = int'(round);
        params_done = (v.params_wait == 0);
        sbox_drdy = (v.sbox_always != 0);
        ke_drdy = 1'b0;
        drdy_i = 1'b1;
        @(posedge clk); #1;
        drdy_i = 1'b0;
        cyc = 1;
        while (!fin && cyc <= 300) begin
            st = int'(stage);
            rd = int'(round);
            if (busy != (st != S_IDLE)) inv_err++;
            if (drdy_o) begin
                n_drdy++;
                if (lat == 0) lat = cyc;
                if (st != S_OUT) inv_err++;
            end
            if (ke_start) begin
                n_kes++;
                if (st != S_ARK) inv_err++;
                ke_due.push_back(cyc + ((rd == v.slow_round) ? v.slow_delay : v.ke_delay));
            end
            if (ke_first_round) begin
                n_kfr++;
                if (!ke_start || rd != 0) inv_err++;
            end
            if (sbox_start) begin
                n_sbs++;
                if (st != S_SB || prev_st == S_SB) inv_err++;
                sb_due.push_back(cyc + v.sbox_delay);
            end
            if (load_data) begin
                n_load++;
                if (st != S_PREP) inv_err++;
            end
`ifdef CLM_WATCHDOG_EN
            if (wd_err) inv_err++;
`endif
            if (st == S_MC) n_mc++;
            if (st == S_KEW) n_kew++;
            if (st == S_KEW && prev_st == S_KEW) long_round = rd;
            if (rd > max_round) max_round = rd;
            if (rd > 10) round_err++;
            if (rd != prev_rd && !(rd == prev_rd + 1 || (rd == 0 && prev_st == S_PREP))) round_err++;

            ke_drdy = 1'b0;
            foreach (ke_due[i]) if (ke_due[i] == cyc) ke_drdy = 1'b1;
            if (!spur_done && v.spur_stage >= 0 && st == v.spur_stage &&
                (v.spur_round < 0 || rd == v.spur_round)) begin
                ke_drdy = 1'b1;
                spur_done = 1;
            end
            sbox_drdy = (v.sbox_always != 0);
            foreach (sb_due[i]) if (sb_due[i] == cyc) sbox_drdy = 1'b1;
            params_done = (cyc > v.params_wait);
            drdy_i = 1'b0;
            if (!extra_done && v.extra_round >= 0 && rd == v.extra_round) begin
                drdy_i = 1'b1;
                extra_done = 1;
            end
            if (lat != 0 && st == S_IDLE) begin
                tail++;
                if (tail > 3) fin = 1;
            end
            prev_st = st;
            prev_rd = rd;
            @(posedge clk); #1;
            cyc++;
        end
        drdy_i = 1'b0; ke_drdy = 1'b0; sbox_drdy = 1'b0; params_done = 1'b0;
        fin_ok = fin;
    endtask

    task automatic check_op(input vec_t v, input int idx);
        check($sformatf("v%0d completion", idx), fin_ok, 1);
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d drdy_o pulses", idx), n_drdy, 1);
        check($sformatf("v%0d ke_start pulses", idx), n_kes, 10);
        check($sformatf("v%0d sbox_start pulses", idx), n_sbs, 10);
        check($sformatf("v%0d ke_first_round pulses", idx), n_kfr, 1);
        check($sformatf("v%0d mix_cols cycles", idx), n_mc, 9);
        check($sformatf("v%0d load_data pulses", idx), n_load, 1);
        check($sformatf("v%0d max round", idx), max_round, 10);
        check($sformatf("v%0d kew cycles", idx), n_kew, v.exp_kew);
        check($sformatf("v%0d long kew round", idx), long_round, v.exp_long_round);
        check($sformatf("v%0d output decode errors", idx), inv_err, 0);
        check($sformatf("v%0d round sequence errors", idx), round_err, 0);
        check($sformatf("v%0d final stage", idx), int'(stage), S_IDLE);
    endtask

    initial begin
        int cnt;
        bit kprev;
        // params_wait sbox_delay sbox_always ke_delay slow_round slow_delay spur_stage spur_round extra_round lat kew long
        vecs[0] = '{0, 1, 0, 1, -1,  0, -1,     -1, -1, 64, 10, -1};
        vecs[1] = '{0, 1, 0, 1,  2, 20, -1,     -1, -1, 79, 25,  3};
        vecs[2] = '{0, 1, 0, 4, -1,  0, -1,     -1, -1, 64, 10, -1};
        vecs[3] = '{0, 1, 0, 1,  0, 20, S_PREP, -1, -1, 79, 25,  1};
        vecs[4] = '{0, 1, 0, 1,  4, 20, S_ARK,   4, -1, 79, 25,  5};
        vecs[5] = '{5, 1, 0, 1, -1,  0, -1,     -1, -1, 69, 10, -1};
        vecs[6] = '{0, 3, 0, 1, -1,  0, -1,     -1, -1, 84, 10, -1};
        vecs[7] = '{0, 1, 1, 1, -1,  0, -1,     -1, -1, 64, 10, -1};
        vecs[8] = '{0, 1, 0, 1, -1,  0, -1,     -1,  4, 64, 10, -1};
        vecs[9] = '{0, 1, 0, 1,  4, 20, S_SB,    5, -1, 64, 10, -1};

        #2 rst = 1'b0;
        #1;
        check("reset stage (async)", int'(stage), S_IDLE);
        @(posedge clk); @(posedge clk); #1;
        check("reset stage", int'(stage), S_IDLE);
        check("reset round", int'(round), 0);
        check("reset busy", int'(busy), 0);
        check("reset pulses", int'({load_data, sbox_start, ke_start, ke_first_round, drdy_o}), 0);
        @(negedge clk) rst = 1'b1;

        params_done = 1'b1; sbox_drdy = 1'b1; ke_drdy = 1'b1; drdy_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle ignores handshakes: stage", int'(stage), S_IDLE);
        check("idle ignores handshakes: busy", int'(busy), 0);
        params_done = 1'b0; sbox_drdy = 1'b0; ke_drdy = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
            check_op(vecs[i], i);
        end

        // asynchronous reset in SUB_BYTES of round 7
        drdy_i = 1'b1; params_done = 1'b1; sbox_drdy = 1'b1; ke_drdy = 1'b0;
        @(posedge clk); #1;
        drdy_i = 1'b0;
        cnt = 0;
        kprev = 1'b0;
        while (!(int'(stage) == S_SB && int'(round) == 7) && cnt < 200) begin
            ke_drdy = kprev;
            kprev = ke_start;
            @(posedge clk); #1;
            cnt++;
        end
        check("reach round 7 sub_bytes", int'(cnt < 200), 1);
        #2 rst = 1'b0;
        #1;
        check("midop reset stage", int'(stage), S_IDLE);
        check("midop reset round", int'(round), 0);
        check("midop reset busy", int'(busy), 0);
        check("midop reset sbox_start", int'(sbox_start), 0);
        ke_drdy = 1'b0; sbox_drdy = 1'b0; params_done = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_op(vecs[0]);
        check_op(vecs[0], 100);

`ifdef CLM_WATCHDOG_EN
        begin
            int sb_cycles, seen_drdy, wd_stage, wd_round, waited;
            drdy_i = 1'b1; params_done = 1'b1; sbox_drdy = 1'b0; ke_drdy = 1'b0;
            @(posedge clk); #1;
            drdy_i = 1'b0;
            sb_cycles = 0; seen_drdy = 0; waited = 0; kprev = 1'b0;
            while (!wd_err && waited < 400) begin
                if (int'(stage) == S_SB) sb_cycles++;
                if (drdy_o) seen_drdy++;
                ke_drdy = kprev;
                kprev = ke_start;
                @(posedge clk); #1;
                waited++;
            end
            check("watchdog fired", int'(wd_err), 1);
            wd_stage = int'(stage);
            wd_round = int'(round);
            check("watchdog sub_bytes cycles", sb_cycles, 255);
            check("watchdog stage", wd_stage, S_IDLE);
            check("watchdog round", wd_round, 0);
            check("watchdog no drdy_o", seen_drdy + int'(drdy_o), 0);
            ke_drdy = 1'b0;
            @(posedge clk); #1;
            check("watchdog pulse width", int'(wd_err), 0);
            run_op(vecs[0]);
            check_op(vecs[0], 200);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
